usi_dma_hs_ctrl: RTL and testbench

- Per-USI DMA handshake controller between the USI sec top (dma_req_tx/rx, dma_ack_tx/rx, tipc trust) and the SoC DMA controller's request/acknowledge ports.
- Registers the level requests from the USI into a clean req/ack handshake toward the DMAC.
- Returns a single-cycle ack pulse to the USI and enforces a hold-off gap so a stale request is not re-issued.
- Adds a request timeout with sticky error flags and saturating transfer counters, and tags each DMAC request with the channel's trust attribute.

---
 rtl/usi_dma_hs_ctrl_if.sv | 34 +++
 rtl/usi_dma_hs_ctrl.sv | 151 +++++++++++++++
 tb/tb_usi_dma_hs_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usi_dma_hs_ctrl_if.sv
// USI <-> DMAC handshake bundle for one USI instance.
// Latency: none (wires only). Backpressure: none; the req/ack handshake itself paces transfers.
// Ports: master = handshake controller side, slave = USI/DMAC/register environment side.
interface usi_dma_hs_ctrl_if;
  logic        hs_en;
  logic        usi_trust;
  logic        usi_req_tx;
  logic        usi_req_rx;
  logic        usi_ack_tx;
  logic        usi_ack_rx;
  logic        dmac_req_tx;
  logic        dmac_req_rx;
  logic        dmac_sec_tx;
  logic        dmac_sec_rx;
  logic        dmac_ack_tx;
  logic        dmac_ack_rx;
  logic        err_clr;
  logic        err_tx;
  logic        err_rx;
  logic [15:0] xfer_cnt_tx;
  logic [15:0] xfer_cnt_rx;

  modport master (
    input  hs_en, usi_trust, usi_req_tx, usi_req_rx, dmac_ack_tx, dmac_ack_rx, err_clr,
    output usi_ack_tx, usi_ack_rx, dmac_req_tx, dmac_req_rx, dmac_sec_tx, dmac_sec_rx,
           err_tx, err_rx, xfer_cnt_tx, xfer_cnt_rx
  );

  modport slave (
    output hs_en, usi_trust, usi_req_tx, usi_req_rx, dmac_ack_tx, dmac_ack_rx, err_clr,
    input  usi_ack_tx, usi_ack_rx, dmac_req_tx, dmac_req_rx, dmac_sec_tx, dmac_sec_rx,
           err_tx, err_rx, xfer_cnt_tx, xfer_cnt_rx
  );
endinterface

// File: rtl/usi_dma_hs_ctrl.sv
// Per-USI DMA handshake controller: level USI requests -> registered DMAC req/ack, one-cycle USI ack.
// Latency: dmac_req one cycle after usi_req sampled; usi_ack one cycle after dmac_ack sampled.
// Backpressure: a request waits in REQ until dmac_ack or timeout; GAP hold-off blocks re-issue.
// Ports: clk, rst_n (async active-low); io_hs carries all USI, DMAC and status signals.

// One channel (TX or RX). Ports: i_usi_req/o_usi_ack toward USI, o_dmac_req/o_dmac_sec/i_dmac_ack
// toward DMAC, i_hs_en/i_trust/i_err_clr controls, o_err/o_xfer_cnt status.
module usi_dma_hs_ch #(
  parameter int HOLDOFF = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hs_en,
  input  logic        i_trust,
  input  logic        i_usi_req,
  input  logic        i_dmac_ack,
  input  logic        i_err_clr,
  output logic        o_usi_ack,
  output logic        o_dmac_req,
  output logic        o_dmac_sec,
  output logic        o_err,
  output logic [15:0] o_xfer_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_GAP} state_t;

  localparam int          TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [15:0] TO_LAST   = 16'(TO_LAST_I);
  localparam logic        TO_EN     = (TIMEOUT > 0);
  localparam logic [3:0]  HOLD_LAST = 4'(HOLDOFF - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_wait;
  logic [3:0]  r_hold;
  logic        r_usi_ack;
  logic        r_dmac_req;
  logic        r_dmac_sec;
  logic        r_err;
  logic [15:0] r_xfer_cnt;

  logic        w_timeout;
  logic        w_dmac_req_nxt;
  logic        w_usi_ack_nxt;
  logic        w_sec_load;
  logic        w_err_set;
  logic        w_cnt_inc;

  // r_wait counts REQ cycles from 0, so REQ lasts exactly TIMEOUT cycles without an ack.
  assign w_timeout = TO_EN && (r_wait == TO_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; ack is tested before timeout so a coincident ack completes normally.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_usi_req && i_hs_en) w_state_nxt = S_REQ;
      S_REQ: begin
        if (i_dmac_ack)     w_state_nxt = S_ACK;
        else if (w_timeout) w_state_nxt = S_GAP;
      end
      S_ACK:   w_state_nxt = S_GAP;
      S_GAP:   if (r_hold == HOLD_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: decoded from the next state so every output comes straight from a flop.
  always_comb begin
    w_dmac_req_nxt = (w_state_nxt == S_REQ);
    w_usi_ack_nxt  = (w_state_nxt == S_ACK);
    w_sec_load     = (r_state == S_IDLE) && (w_state_nxt == S_REQ);
    // REQ -> GAP only happens on timeout (the ack path goes through ACK).
    w_err_set      = (r_state == S_REQ) && (w_state_nxt == S_GAP);
    w_cnt_inc      = w_usi_ack_nxt && (r_xfer_cnt != 16'hFFFF);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait     <= '0;
      r_hold     <= '0;
      r_usi_ack  <= 1'b0;
      r_dmac_req <= 1'b0;
      r_dmac_sec <= 1'b0;
      r_err      <= 1'b0;
      r_xfer_cnt <= '0;
    end else begin
      r_wait     <= (r_state == S_REQ) ? r_wait + 16'd1 : 16'd0;
      r_hold     <= (r_state == S_GAP) ? r_hold + 4'd1 : 4'd0;
      r_usi_ack  <= w_usi_ack_nxt;
      r_dmac_req <= w_dmac_req_nxt;
      // Trust is captured only at issue, so it cannot change under an outstanding request.
      if (w_sec_load) r_dmac_sec <= i_trust;
      // A new timeout outranks a simultaneous clear.
      if (w_err_set)      r_err <= 1'b1;
      else if (i_err_clr) r_err <= 1'b0;
      if (w_cnt_inc) r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign o_usi_ack  = r_usi_ack;
  assign o_dmac_req = r_dmac_req;
  assign o_dmac_sec = r_dmac_sec;
  assign o_err      = r_err;
  assign o_xfer_cnt = r_xfer_cnt;
endmodule

module usi_dma_hs_ctrl #(
  parameter int HOLDOFF = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  usi_dma_hs_ctrl_if.master io_hs
);
  // TX and RX are fully independent channel instances.
  usi_dma_hs_ch #(.HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)) u_tx (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_hs_en    (io_hs.hs_en),
    .i_trust    (io_hs.usi_trust),
    .i_usi_req  (io_hs.usi_req_tx),
    .i_dmac_ack (io_hs.dmac_ack_tx),
    .i_err_clr  (io_hs.err_clr),
    .o_usi_ack  (io_hs.usi_ack_tx),
    .o_dmac_req (io_hs.dmac_req_tx),
    .o_dmac_sec (io_hs.dmac_sec_tx),
    .o_err      (io_hs.err_tx),
    .o_xfer_cnt (io_hs.xfer_cnt_tx)
  );

  usi_dma_hs_ch #(.HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)) u_rx (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_hs_en    (io_hs.hs_en),
    .i_trust    (io_hs.usi_trust),
    .i_usi_req  (io_hs.usi_req_rx),
    .i_dmac_ack (io_hs.dmac_ack_rx),
    .i_err_clr  (io_hs.err_clr),
    .o_usi_ack  (io_hs.usi_ack_rx),
    .o_dmac_req (io_hs.dmac_req_rx),
    .o_dmac_sec (io_hs.dmac_sec_rx),
    .o_err      (io_hs.err_rx),
    .o_xfer_cnt (io_hs.xfer_cnt_rx)
  );
endmodule

// File: tb/tb_usi_dma_hs_ctrl.sv
// Directed self-checking bench for usi_dma_hs_ctrl (HOLDOFF=2, TIMEOUT=8).
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: the bench plays both USI and DMAC roles.
module tb_usi_dma_hs_ctrl;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  usi_dma_hs_ctrl_if u_if ();

  usi_dma_hs_ctrl #(.HOLDOFF(2), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_hs (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cnt;
    int ack_cnt;
    int n_rise;
    int rises[8];
    logic prev;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    u_if.hs_en       = 1'b0;
    u_if.usi_trust   = 1'b0;
    u_if.usi_req_tx  = 1'b0;
    u_if.usi_req_rx  = 1'b0;
    u_if.dmac_ack_tx = 1'b0;
    u_if.dmac_ack_rx = 1'b0;
    u_if.err_clr     = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_dmac_req_tx", u_if.dmac_req_tx, 0);
    check("rst_dmac_req_rx", u_if.dmac_req_rx, 0);
    check("rst_usi_ack_tx", u_if.usi_ack_tx, 0);
    check("rst_err_rx", u_if.err_rx, 0);
    check("rst_cnt_tx", u_if.xfer_cnt_tx, 0);
    rst_n = 1'b1;
    tick();

    // Single TX: req at cycle 0, DMAC ack in cycle 4, usi_ack in cycle 5
    u_if.hs_en      = 1'b1;
    u_if.usi_req_tx = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("t1_dmac_req", u_if.dmac_req_tx, 1);
      check("t1_no_ack", u_if.usi_ack_tx, 0);
      if (c == 4) u_if.dmac_ack_tx = 1'b1;
    end
    tick();
    u_if.dmac_ack_tx = 1'b0;
    u_if.usi_req_tx  = 1'b0;
    check("t1_req_drop", u_if.dmac_req_tx, 0);
    check("t1_usi_ack", u_if.usi_ack_tx, 1);
    check("t1_cnt", u_if.xfer_cnt_tx, 1);
    check("t1_sec", u_if.dmac_sec_tx, 0);
    tick();
    check("t1_ack_one_cycle", u_if.usi_ack_tx, 0);
    tick();
    tick();

    // Timeout on RX; err_clr held on the timeout edge must lose to the set
    u_if.usi_req_rx = 1'b1;
    hi_cnt  = 0;
    ack_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      u_if.usi_req_rx = 1'b0;
      u_if.err_clr    = (i == 8);
      hi_cnt  += int'(u_if.dmac_req_rx);
      ack_cnt += int'(u_if.usi_ack_rx);
      if (i == 8) check("t2_err_before", u_if.err_rx, 0);
      if (i == 9) check("t2_err_set", u_if.err_rx, 1);
    end
    check("t2_req_cycles", hi_cnt, 8);
    check("t2_no_usi_ack", ack_cnt, 0);
    check("t2_cnt_rx", u_if.xfer_cnt_rx, 0);
    check("t2_err_sticky", u_if.err_rx, 1);
    check("t2_err_tx_clean", u_if.err_tx, 0);
    u_if.err_clr = 1'b1;
    tick();
    u_if.err_clr = 1'b0;
    check("t2_err_clr", u_if.err_rx, 0);

    // Ack on the timeout-reaching edge: ack wins
    u_if.usi_req_rx = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      u_if.usi_req_rx = 1'b0;
    end
    check("t2b_req_last", u_if.dmac_req_rx, 1);
    u_if.dmac_ack_rx = 1'b1;
    tick();
    u_if.dmac_ack_rx = 1'b0;
    check("t2b_usi_ack", u_if.usi_ack_rx, 1);
    check("t2b_no_err", u_if.err_rx, 0);
    check("t2b_cnt_rx", u_if.xfer_cnt_rx, 1);
    repeat (3) tick();

    // Hold-off: level request held, DMAC acks every first REQ cycle
    u_if.usi_req_tx = 1'b1;
    prev    = 1'b0;
    n_rise  = 0;
    hi_cnt  = 0;
    ack_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      u_if.dmac_ack_tx = u_if.dmac_req_tx;
      hi_cnt  += int'(u_if.dmac_req_tx);
      ack_cnt += int'(u_if.usi_ack_tx);
      if (u_if.dmac_req_tx && !prev && n_rise < 8) begin
        rises[n_rise] = i;
        n_rise++;
      end
      prev = u_if.dmac_req_tx;
    end
    u_if.usi_req_tx  = 1'b0;
    u_if.dmac_ack_tx = 1'b0;
    check("t3_n_issue", n_rise, 4);
    check("t3_req_cycles", hi_cnt, 4);
    check("t3_usi_acks", ack_cnt, 4);
    check("t3_rise0", rises[0], 1);
    check("t3_rise1", rises[1], 6);
    check("t3_rise3", rises[3], 16);
    check("t3_cnt_tx", u_if.xfer_cnt_tx, 5);
    repeat (2) tick();

    // Trust / parallel channels
    u_if.usi_trust  = 1'b1;
    u_if.usi_req_tx = 1'b1;
    u_if.usi_req_rx = 1'b1;
    tick();
    check("t4_req_tx", u_if.dmac_req_tx, 1);
    check("t4_req_rx", u_if.dmac_req_rx, 1);
    check("t4_sec_tx", u_if.dmac_sec_tx, 1);
    check("t4_sec_rx", u_if.dmac_sec_rx, 1);
    u_if.usi_req_tx  = 1'b0;
    u_if.usi_req_rx  = 1'b0;
    u_if.usi_trust   = 1'b0;
    u_if.dmac_ack_tx = 1'b1;
    tick();
    u_if.dmac_ack_tx = 1'b0;
    u_if.dmac_ack_rx = 1'b1;
    check("t4_ack_tx", u_if.usi_ack_tx, 1);
    check("t4_ack_rx_idle", u_if.usi_ack_rx, 0);
    check("t4_rx_still_req", u_if.dmac_req_rx, 1);
    check("t4_sec_rx_held", u_if.dmac_sec_rx, 1);
    tick();
    u_if.dmac_ack_rx = 1'b0;
    u_if.dmac_ack_tx = 1'b1;   // TX is in GAP: must be ignored
    check("t4_ack_rx", u_if.usi_ack_rx, 1);
    check("t4_ack_tx_off", u_if.usi_ack_tx, 0);
    tick();
    u_if.dmac_ack_tx = 1'b0;
    check("t4_stray_ack", u_if.usi_ack_tx, 0);
    check("t4_cnt_tx", u_if.xfer_cnt_tx, 6);
    check("t4_cnt_rx", u_if.xfer_cnt_rx, 2);
    repeat (3) tick();

    // Enable gating and hs_en drop inside REQ
    u_if.hs_en      = 1'b0;
    u_if.usi_req_tx = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      hi_cnt += int'(u_if.dmac_req_tx);
    end
    check("t5_gated", hi_cnt, 0);
    u_if.hs_en = 1'b1;
    tick();
    u_if.hs_en      = 1'b0;
    u_if.usi_req_tx = 1'b0;
    check("t5_issue", u_if.dmac_req_tx, 1);
    tick();
    tick();
    check("t5_no_abort", u_if.dmac_req_tx, 1);
    u_if.dmac_ack_tx = 1'b1;
    tick();
    u_if.dmac_ack_tx = 1'b0;
    check("t5_complete", u_if.usi_ack_tx, 1);
    check("t5_cnt_tx", u_if.xfer_cnt_tx, 7);
    repeat (3) tick();

    // Saturation: preload the TX counter just below the ceiling
    force dut.u_tx.r_xfer_cnt = 16'hFFFE;
    #1;
    release dut.u_tx.r_xfer_cnt;
    u_if.hs_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      u_if.usi_req_tx = 1'b1;
      tick();
      u_if.usi_req_tx  = 1'b0;
      u_if.dmac_ack_tx = 1'b1;
      tick();
      u_if.dmac_ack_tx = 1'b0;
      check("t6_sat", u_if.xfer_cnt_tx, 32'hFFFF);
      repeat (3) tick();
    end

    // Asynchronous reset in the middle of REQ
    u_if.usi_req_tx = 1'b1;
    tick();
    check("t7_in_req", u_if.dmac_req_tx, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_req_async", u_if.dmac_req_tx, 0);
    check("t7_cnt_async", u_if.xfer_cnt_tx, 0);
    u_if.usi_req_tx = 1'b0;
    tick();
    rst_n = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      hi_cnt += int'(u_if.dmac_req_tx) + int'(u_if.dmac_req_rx) + int'(u_if.usi_ack_tx)
              + int'(u_if.usi_ack_rx) + int'(u_if.dmac_sec_tx) + int'(u_if.dmac_sec_rx)
              + int'(u_if.err_tx) + int'(u_if.err_rx);
    end
    check("t7_quiet", hi_cnt, 0);
    check("t7_cnt_rx", u_if.xfer_cnt_rx, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
